exe_issue: RTL and testbench
============================

EXE_ISSUE -- requirements
Module: exe_issue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: request queue entries, power of two, 2..16.
REQ-002 SHALL have parameter TIMEOUT, default 8: max cycles spent in WAIT before an error writeback, 2..255.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst_n, input, 1: synchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 1: upstream request present.
REQ-006 SHALL have port req_ready, output, 1: queue can accept a request.
REQ-007 SHALL have port req_op, input, 1: 0 = add, 1 = subtract (a-b).
REQ-008 SHALL have ports req_a and req_b, input, 32 each: operands.
REQ-009 SHALL have port req_tag, input, 4: request identifier, returned on writeback.
REQ-010 SHALL have port exe_start, output, 1: one-cycle start pulse to the execution unit.
REQ-011 SHALL have port exe_op, output, 1: operation driven to the execution unit.
REQ-012 SHALL have ports exe_a and exe_b, output, 32 each: operands driven to the execution unit.
REQ-013 SHALL have port exe_valid, input, 1: execution unit result ready.
REQ-014 SHALL have port exe_result, input, 32: execution unit result.
REQ-015 SHALL have port wb_valid, output, 1: one-cycle writeback pulse.
REQ-016 SHALL have port wb_tag, output, 4: tag of the completed request.
REQ-017 SHALL have port wb_result, output, 32: result; 0 on error.
REQ-018 SHALL have port wb_err, output, 1: request timed out.

Function
REQ-019 Queue SHALL be FIFO-ordered (op, a, b, tag); push when req_valid && req_ready; req_ready = !full.
REQ-020 When full, req_ready SHALL be 0 regardless of a same-cycle pop; push and pop in one cycle when not full SHALL both take effect, count unchanged.
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT: IDLE->ISSUE when queue non-empty; ISSUE->WAIT unconditionally; WAIT->IDLE on exe_valid or timeout.
REQ-022 exe_start SHALL be 1 exactly in ISSUE (one cycle per request); exe_op/a/b SHALL equal the queue head from ISSUE through the last WAIT cycle, 0 in IDLE.
REQ-023 A WAIT cycle counter SHALL clear on entering WAIT and increment each WAIT cycle; exe_valid in IDLE or ISSUE SHALL be ignored.
REQ-024 On exe_valid in WAIT: the next cycle SHALL show wb_valid=1, wb_result=exe_result sampled, wb_tag=head tag, wb_err=0; head popped at the same edge.
REQ-025 If TIMEOUT WAIT cycles elapse without exe_valid: the next cycle SHALL show wb_valid=1, wb_err=1, wb_result=0, wb_tag=head tag; head popped; state IDLE.
REQ-026 exe_valid and timeout in the same cycle: exe_valid SHALL win (wb_err=0).
REQ-027 wb_* SHALL be 0 whenever wb_valid=0.
REQ-028 Minimum latency, push edge to wb_valid: 3 cycles + execution-unit latency; at most one request in flight.
REQ-029 Queue pointers SHALL wrap modulo DEPTH with no lost or duplicated entries.

Reset
REQ-030 On rst_n=0 at a clock edge: state IDLE, queue empty, counter 0, req_ready=1 the following cycle, all other outputs 0.
REQ-031 Reset in ISSUE or WAIT SHALL abort the in-flight request with no writeback; a late exe_valid after reset SHALL be ignored.

Structure
REQ-032 A shared package exe_pkg SHALL hold the FSM state type, OP_ADD=1'b0, OP_SUB=1'b1, data width 32, and tag width 4.
REQ-033 The queue SHALL be a separate sub-module exe_issue_fifo (parameterised DEPTH/width, push/pop/full/empty).

Verification
REQ-034 Single add, op=0, a=5, b=7, tag=3, unit responds 2 cycles after start -> exactly one exe_start; wb_valid with wb_result=12, wb_tag=3, wb_err=0.
REQ-035 Subtract, a=0, b=1 -> wb_result=32'hFFFFFFFF; exe_a/exe_b stable through WAIT.
REQ-036 Push 5 requests back-to-back, DEPTH=4, unit stalled -> req_ready=0 after 4 pushes; writebacks return tags in push order.
REQ-037 Unit never asserts exe_valid, TIMEOUT=8 -> wb_err=1, wb_result=0 after 8 WAIT cycles; next request then issues normally.
REQ-038 rst_n=0 during WAIT with 2 queued -> no writeback, queue empty, outputs 0; a subsequent request completes correctly.
REQ-039 Spurious exe_valid in IDLE, and exe_valid coinciding with the timeout cycle -> the first is ignored; the second gives wb_err=0.

Source files
------------

// File: rtl/exe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exe_pkg
// Description : Shared types and constants for the exe_issue request issuer.
// Revision    : 1.0 - initial release
// ============================================================================
package exe_pkg;

    localparam int unsigned c_DATA_W = 32;
    localparam int unsigned c_TAG_W  = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic                op;
        logic [c_DATA_W-1:0] a;
        logic [c_DATA_W-1:0] b;
        logic [c_TAG_W-1:0]  tag;
    } req_t;

    localparam int unsigned c_REQ_W = $bits(req_t);

endpackage
`default_nettype wire

// File: rtl/exe_issue_fifo.sv
`default_nettype none
// ============================================================================
// Module      : exe_issue_fifo
// Description : Power-of-two FIFO holding pending issue requests.
// Revision    : 1.0 - initial release
// ============================================================================
module exe_issue_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 69
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned    c_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_AW:0]  c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == c_FULL);
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign rdata     = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/exe_issue.sv
`default_nettype none
// ============================================================================
// Module      : exe_issue
// Description : Queues add/sub requests and issues them one at a time to an
//               execution unit, with timeout-protected writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module exe_issue
    import exe_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_op,
    input  logic [c_DATA_W-1:0] req_a,
    input  logic [c_DATA_W-1:0] req_b,
    input  logic [c_TAG_W-1:0]  req_tag,
    output logic                exe_start,
    output logic                exe_op,
    output logic [c_DATA_W-1:0] exe_a,
    output logic [c_DATA_W-1:0] exe_b,
    input  logic                exe_valid,
    input  logic [c_DATA_W-1:0] exe_result,
    output logic                wb_valid,
    output logic [c_TAG_W-1:0]  wb_tag,
    output logic [c_DATA_W-1:0] wb_result,
    output logic                wb_err
);

    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t              r_state;
    logic [7:0]          r_cnt;
    logic                r_wb_valid;
    logic [c_TAG_W-1:0]  r_wb_tag;
    logic [c_DATA_W-1:0] r_wb_result;
    logic                r_wb_err;

    req_t                w_push_req;
    req_t                w_head;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_busy;
    logic                w_timeout;

    assign w_push_req = {req_op, req_a, req_b, req_tag};
    assign req_ready  = !w_full;
    assign w_push     = req_valid && !w_full;
    assign w_timeout  = (r_cnt == c_TIMEOUT_LAST);
    // The head leaves the queue on the same edge that produces its writeback.
    assign w_pop      = (r_state == ST_WAIT) && (exe_valid || w_timeout);

    exe_issue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_REQ_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .wdata (w_push_req),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_busy    = (r_state != ST_IDLE);
    assign exe_start = (r_state == ST_ISSUE);
    assign exe_op    = w_busy ? w_head.op : 1'b0;
    assign exe_a     = w_busy ? w_head.a  : '0;
    assign exe_b     = w_busy ? w_head.b  : '0;

    assign wb_valid  = r_wb_valid;
    assign wb_tag    = r_wb_tag;
    assign wb_result = r_wb_result;
    assign wb_err    = r_wb_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_tag    <= '0;
            r_wb_result <= '0;
            r_wb_err    <= 1'b0;
        end else begin
            r_wb_valid  <= 1'b0;
            r_wb_tag    <= '0;
            r_wb_result <= '0;
            r_wb_err    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                    r_cnt   <= '0;
                end
                ST_WAIT: begin
                    // A response in the timeout cycle still counts as success.
                    if (exe_valid) begin
                        r_state     <= ST_IDLE;
                        r_wb_valid  <= 1'b1;
                        r_wb_tag    <= w_head.tag;
                        r_wb_result <= exe_result;
                    end else if (w_timeout) begin
                        r_state    <= ST_IDLE;
                        r_wb_valid <= 1'b1;
                        r_wb_tag   <= w_head.tag;
                        r_wb_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exe_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_exe_issue
// Description : Directed self-checking bench for exe_issue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exe_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_tag;
    logic        exe_start;
    logic        exe_op;
    logic [31:0] exe_a;
    logic [31:0] exe_b;
    logic        exe_valid;
    logic [31:0] exe_result;
    logic        wb_valid;
    logic [3:0]  wb_tag;
    logic [31:0] wb_result;
    logic        wb_err;

    int checks   = 0;
    int errors   = 0;
    int n_starts = 0;
    int starts_snap;

    exe_issue #(
        .DEPTH   (4),
        .TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .exe_start  (exe_start),
        .exe_op     (exe_op),
        .exe_a      (exe_a),
        .exe_b      (exe_b),
        .exe_valid  (exe_valid),
        .exe_result (exe_result),
        .wb_valid   (wb_valid),
        .wb_tag     (wb_tag),
        .wb_result  (wb_result),
        .wb_err     (wb_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exe_start === 1'b1) n_starts++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        tick();
        req_valid = 1'b0;
    endtask

    // Wait for the issue pulse, answer after 'delay' WAIT cycles, check writeback.
    task automatic serve(input logic [3:0] t, input logic op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r, input int delay);
        int n = 0;
        while (exe_start !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        chk("start_seen", {31'd0, exe_start}, 32'd1);
        repeat (delay) tick();
        chk("wait_op", {31'd0, exe_op}, {31'd0, op});
        chk("wait_a", exe_a, a);
        chk("wait_b", exe_b, b);
        exe_valid  = 1'b1;
        exe_result = r;
        tick();
        exe_valid  = 1'b0;
        exe_result = 32'h0;
        chk("wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("wb_tag", {28'd0, wb_tag}, {28'd0, t});
        chk("wb_result", wb_result, r);
        chk("wb_err", {31'd0, wb_err}, 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 1'b0;
        req_a      = 32'h0;
        req_b      = 32'h0;
        req_tag    = 4'h0;
        exe_valid  = 1'b0;
        exe_result = 32'h0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_start", {31'd0, exe_start}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_exe_a", exe_a, 32'd0);
        n_starts = 0;

        // Single add, unit answers two cycles after start: 5+7=12
        push(1'b0, 32'd5, 32'd7, 4'd3);
        serve(4'd3, 1'b0, 32'd5, 32'd7, 32'd12, 2);
        chk("add_starts", n_starts, 32'd1);
        chk("add_idle_a", exe_a, 32'd0);
        tick();
        chk("add_pulse", {31'd0, wb_valid}, 32'd0);
        chk("add_wb_zero", wb_result, 32'd0);

        // Subtract 0-1 wraps to all ones
        push(1'b1, 32'd0, 32'd1, 4'd5);
        serve(4'd5, 1'b1, 32'd0, 32'd1, 32'hFFFF_FFFF, 2);

        // Five back-to-back pushes with a stalled unit
        push(1'b0, 32'd10, 32'd1, 4'd1);
        push(1'b0, 32'd20, 32'd1, 4'd2);
        push(1'b0, 32'd30, 32'd1, 4'd3);
        req_valid = 1'b1;
        req_op    = 1'b0;
        req_a     = 32'd40;
        req_b     = 32'd1;
        req_tag   = 4'd4;
        tick();
        chk("full_ready", {31'd0, req_ready}, 32'd0);
        req_a   = 32'd50;
        req_tag = 4'd5;
        tick();
        chk("full_ready_hold", {31'd0, req_ready}, 32'd0);
        chk("full_head_a", exe_a, 32'd10);
        exe_valid  = 1'b1;
        exe_result = 32'd11;
        tick();
        exe_valid = 1'b0;
        chk("fifo_wb_tag1", {28'd0, wb_tag}, 32'd1);
        chk("fifo_wb_res1", wb_result, 32'd11);
        chk("fifo_ready_after_pop", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        serve(4'd2, 1'b0, 32'd20, 32'd1, 32'd21, 1);
        serve(4'd3, 1'b0, 32'd30, 32'd1, 32'd31, 1);
        serve(4'd4, 1'b0, 32'd40, 32'd1, 32'd41, 1);
        serve(4'd5, 1'b0, 32'd50, 32'd1, 32'd51, 1);

        // Timeout: eight silent WAIT cycles give an error writeback
        push(1'b0, 32'd1, 32'd2, 4'd7);
        for (int n = 0; n < 30 && exe_start !== 1'b1; n++) tick();
        exe_result = 32'hDEAD_BEEF;
        tick();
        repeat (7) tick();
        chk("to_not_yet", {31'd0, wb_valid}, 32'd0);
        tick();
        chk("to_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("to_wb_err", {31'd0, wb_err}, 32'd1);
        chk("to_wb_result", wb_result, 32'd0);
        chk("to_wb_tag", {28'd0, wb_tag}, 32'd7);
        exe_result = 32'h0;
        push(1'b0, 32'd3, 32'd4, 4'd8);
        serve(4'd8, 1'b0, 32'd3, 32'd4, 32'd7, 1);

        // Reset while WAITing with two more queued
        push(1'b0, 32'd1, 32'd1, 4'd9);
        push(1'b0, 32'd2, 32'd2, 4'd10);
        push(1'b0, 32'd3, 32'd3, 4'd11);
        chk("pre_rst_a", exe_a, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n      = 1'b1;
        exe_valid  = 1'b1;
        exe_result = 32'd99;
        chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rst_start", {31'd0, exe_start}, 32'd0);
        chk("mid_rst_a", exe_a, 32'd0);
        chk("mid_rst_wb", {31'd0, wb_valid}, 32'd0);
        tick();
        exe_valid = 1'b0;
        chk("late_valid_wb", {31'd0, wb_valid}, 32'd0);
        starts_snap = n_starts;
        repeat (3) tick();
        chk("rst_queue_empty", n_starts, starts_snap);
        push(1'b0, 32'd40, 32'd2, 4'd12);
        serve(4'd12, 1'b0, 32'd40, 32'd2, 32'd42, 1);

        // Spurious exe_valid in IDLE, then exe_valid on the timeout cycle
        exe_valid  = 1'b1;
        exe_result = 32'd77;
        tick();
        tick();
        exe_valid = 1'b0;
        chk("idle_valid_wb", {31'd0, wb_valid}, 32'd0);
        push(1'b1, 32'd100, 32'd50, 4'd13);
        serve(4'd13, 1'b1, 32'd100, 32'd50, 32'd50, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
